// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU microstep sequencer: opcodes, control-word
// bit positions, ALU operation encodings and the sequencer state enum.
package cpu_pkg;

    localparam int CTRL_W = 16;

    // Opcodes (IR high nibble)
    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_STA = 4'b0101;
    localparam logic [3:0] OP_LDI = 4'b0110;
    localparam logic [3:0] OP_SUB = 4'b0111;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control-word bit positions, MSB first
    localparam int BIT_PC_IN     = 15;
    localparam int BIT_PC_OUT    = 14;
    localparam int BIT_PC_ADD    = 13;
    localparam int BIT_MAR_IN    = 12;
    localparam int BIT_RAM_IN    = 11;
    localparam int BIT_RAM_OUT   = 10;
    localparam int BIT_IR_IN     = 9;
    localparam int BIT_IR_OUT    = 8;
    localparam int BIT_A_IN      = 7;
    localparam int BIT_A_IMM_IN  = 6;
    localparam int BIT_A_OUT     = 5;
    localparam int BIT_B_IN      = 4;
    localparam int BIT_ALU_OUT   = 3;
    localparam int BIT_OUTPUT_IN = 2;
    localparam int ALU_OP_LSB    = 0;

    // alu_op encodings
    localparam logic [1:0] ALU_NONE = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    // One-hot control word with a single signal asserted
    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

    // Control word carrying only an alu_op value
    function automatic logic [CTRL_W-1:0] alu_word(input logic [1:0] op);
        return CTRL_W'(op) << ALU_OP_LSB;
    endfunction

endpackage

// File: rtl/ucode_rom.sv
// Combinational microcode ROM: (opcode, step) -> control word for that step
// plus a flag saying whether that step is the last one of the instruction.
module ucode_rom
    import cpu_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [2:0]        step,
    output logic [CTRL_W-1:0] ctrl,
    output logic              last_step
);

    localparam logic [CTRL_W-1:0] PC_IN     = cbit(BIT_PC_IN);
    localparam logic [CTRL_W-1:0] PC_OUT    = cbit(BIT_PC_OUT);
    localparam logic [CTRL_W-1:0] PC_ADD    = cbit(BIT_PC_ADD);
    localparam logic [CTRL_W-1:0] MAR_IN    = cbit(BIT_MAR_IN);
    localparam logic [CTRL_W-1:0] RAM_IN    = cbit(BIT_RAM_IN);
    localparam logic [CTRL_W-1:0] RAM_OUT   = cbit(BIT_RAM_OUT);
    localparam logic [CTRL_W-1:0] IR_IN     = cbit(BIT_IR_IN);
    localparam logic [CTRL_W-1:0] IR_OUT    = cbit(BIT_IR_OUT);
    localparam logic [CTRL_W-1:0] A_IN      = cbit(BIT_A_IN);
    localparam logic [CTRL_W-1:0] A_IMM_IN  = cbit(BIT_A_IMM_IN);
    localparam logic [CTRL_W-1:0] A_OUT     = cbit(BIT_A_OUT);
    localparam logic [CTRL_W-1:0] B_IN      = cbit(BIT_B_IN);
    localparam logic [CTRL_W-1:0] ALU_OUT   = cbit(BIT_ALU_OUT);
    localparam logic [CTRL_W-1:0] OUTPUT_IN = cbit(BIT_OUTPUT_IN);

    // Microcode lookup; unused slots give an empty word marked as last
    always_comb begin
        ctrl      = '0;
        last_step = 1'b1;
        case (step)
            3'd1: begin
                ctrl      = PC_OUT | MAR_IN;
                last_step = 1'b0;
            end
            3'd2: begin
                ctrl = RAM_OUT | IR_IN | PC_ADD;
                case (opcode)
                    OP_LDA, OP_ADD, OP_OUT, OP_JMP,
                    OP_STA, OP_LDI, OP_SUB, OP_HLT: last_step = 1'b0;
                    default:                        last_step = 1'b1;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl      = IR_OUT | MAR_IN;
                        last_step = 1'b0;
                    end
                    OP_OUT:  ctrl = A_OUT | OUTPUT_IN;
                    OP_JMP:  ctrl = IR_OUT | PC_IN;
                    OP_LDI:  ctrl = IR_OUT | A_IMM_IN;
                    default: ctrl = '0;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_LDA: ctrl = RAM_OUT | A_IN;
                    OP_ADD, OP_SUB: begin
                        ctrl      = RAM_OUT | B_IN;
                        last_step = 1'b0;
                    end
                    OP_STA:  ctrl = A_OUT | RAM_IN;
                    default: ctrl = '0;
                endcase
            end
            3'd5: begin
                case (opcode)
                    OP_ADD:  ctrl = ALU_OUT | A_IN | alu_word(ALU_ADD);
                    OP_SUB:  ctrl = ALU_OUT | A_IN | alu_word(ALU_SUB);
                    default: ctrl = '0;
                endcase
            end
            default: begin
                ctrl      = '0;
                last_step = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// CPU microstep sequencer. Advances one microstep per step_en strobe and
// presents a registered control word for the step in progress. Handles
// free-run, pause at instruction boundaries, single-step and halt/restart.
// Handshake note: single and start are one-clk pulses with no ready; they are
// latched while the FSM is in the state that consumes them (PAUSE / HALTED)
// and held until the next step_en acts on them; elsewhere they are ignored.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int MAX_STEP = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_en,
    input  logic [3:0]        opcode,
    input  logic              run,
    input  logic              single,
    input  logic              start,
    output logic [CTRL_W-1:0] ctrl,
    output logic [2:0]        step,
    output logic              halted,
    output logic              paused,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] LAST_IDX = 3'(MAX_STEP);

    state_t            state_q, state_d;
    logic [2:0]        step_q, step_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              last_q, last_d;
    logic              single_pend_q, single_pend_d;
    logic              start_pend_q, start_pend_d;

    logic [2:0]        rom_step;
    logic [CTRL_W-1:0] rom_ctrl;
    logic              rom_last;
    logic              single_seen;
    logic              start_seen;
    logic              advance;
    logic              to_pause;
    logic              to_halt;

    // Step that follows the current one; anything past the last step or past
    // MAX_STEP restarts at FETCH T1
    always_comb begin
        rom_step = 3'd1;
        if ((state_q == ST_FETCH || state_q == ST_EXEC) && !last_q &&
            step_q != 3'd0 && step_q < LAST_IDX) begin
            rom_step = step_q + 3'd1;
        end
    end

    ucode_rom u_rom (
        .opcode    (opcode),
        .step      (rom_step),
        .ctrl      (rom_ctrl),
        .last_step (rom_last)
    );

    // Next-state logic: state moves only on step_en; pulse latches update any cycle
    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        ctrl_d        = ctrl_q;
        last_d        = last_q;
        single_seen   = single_pend_q | (single & (state_q == ST_PAUSE));
        start_seen    = start_pend_q | (start & (state_q == ST_HALTED));
        single_pend_d = single_seen;
        start_pend_d  = start_seen;
        advance       = 1'b0;
        to_pause      = 1'b0;
        to_halt       = 1'b0;

        if (step_en) begin
            case (state_q)
                ST_IDLE: advance = 1'b1;
                ST_FETCH, ST_EXEC: begin
                    if (last_q) begin
                        if (opcode == OP_HLT && step_q >= 3'd3) begin
                            to_halt = 1'b1;
                        end else if (run) begin
                            advance = 1'b1;
                        end else begin
                            to_pause = 1'b1;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (run || single_seen) begin
                        advance       = 1'b1;
                        single_pend_d = 1'b0;
                    end
                end
                ST_HALTED: begin
                    if (start_seen) begin
                        advance      = 1'b1;
                        start_pend_d = 1'b0;
                    end
                end
                default: to_pause = 1'b0;
            endcase

            if (advance) begin
                state_d = (rom_step >= 3'd3) ? ST_EXEC : ST_FETCH;
                step_d  = rom_step;
                ctrl_d  = rom_ctrl;
                last_d  = rom_last;
            end else if (to_pause || to_halt) begin
                state_d = to_halt ? ST_HALTED : ST_PAUSE;
                step_d  = 3'd0;
                ctrl_d  = '0;
                last_d  = 1'b0;
            end else if (state_q != ST_PAUSE && state_q != ST_HALTED) begin
                // Unknown encoding: recover to IDLE with outputs quiet
                state_d = ST_IDLE;
                step_d  = 3'd0;
                ctrl_d  = '0;
                last_d  = 1'b0;
            end
        end
    end

    // State registers; reset drops ctrl immediately so no partial pulse survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            step_q        <= 3'd0;
            ctrl_q        <= '0;
            last_q        <= 1'b0;
            single_pend_q <= 1'b0;
            start_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            ctrl_q        <= ctrl_d;
            last_q        <= last_d;
            single_pend_q <= single_pend_d;
            start_pend_q  <= start_pend_d;
        end
    end

    assign ctrl      = ctrl_q;
    assign step      = step_q;
    assign halted    = (state_q == ST_HALTED);
    assign paused    = (state_q == ST_PAUSE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: table of directed vectors, hand-written
// pause/single, halt/start and async-reset sequences, then randomized
// instruction streams checked against an instruction-level model.
module tb_cpu_sequencer;

    // Control-word masks written out from the signal ordering
    localparam logic [15:0] PC_IN   = 16'h8000;
    localparam logic [15:0] PC_OUT  = 16'h4000;
    localparam logic [15:0] PC_ADD  = 16'h2000;
    localparam logic [15:0] MAR_IN  = 16'h1000;
    localparam logic [15:0] RAM_IN  = 16'h0800;
    localparam logic [15:0] RAM_OUT = 16'h0400;
    localparam logic [15:0] IR_IN   = 16'h0200;
    localparam logic [15:0] IR_OUT  = 16'h0100;
    localparam logic [15:0] A_IN    = 16'h0080;
    localparam logic [15:0] A_IMM   = 16'h0040;
    localparam logic [15:0] A_OUT   = 16'h0020;
    localparam logic [15:0] B_IN    = 16'h0010;
    localparam logic [15:0] ALU_OUT = 16'h0008;
    localparam logic [15:0] OUT_IN  = 16'h0004;
    localparam logic [15:0] ALU_A   = 16'h0001;
    localparam logic [15:0] ALU_S   = 16'h0002;
    localparam logic [15:0] W_T1    = PC_OUT | MAR_IN;
    localparam logic [15:0] W_T2    = RAM_OUT | IR_IN | PC_ADD;

    localparam int W = 21;  // {ctrl, step, halted, paused}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step_en = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        run = 1'b0;
    logic        single = 1'b0;
    logic        start = 1'b0;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;
    logic        paused;
    logic [2:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [15:0] ec;
        logic [2:0]  es;
    } vec_t;
    vec_t tbl[$];

    // Model state for randomized runs
    logic [15:0] words[0:4];
    int          nwords;

    cpu_sequencer #(.MAX_STEP(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .opcode    (opcode),
        .run       (run),
        .single    (single),
        .start     (start),
        .ctrl      (ctrl),
        .step      (step),
        .halted    (halted),
        .paused    (paused),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] ec, input logic [2:0] es,
                         input logic eh, input logic ep);
        vectors++;
        if ({ctrl, step, halted, paused} !== {ec, es, eh, ep}) begin
            miscompares++;
            $display("FAIL %s: got ctrl=%h step=%0d halted=%b paused=%b, want ctrl=%h step=%0d halted=%b paused=%b",
                     name, ctrl, step, halted, paused, ec, es, eh, ep);
        end
    endtask

    // One step_en strobe after 'gap' idle cycles; returns at the following negedge
    task automatic do_step(input int gap);
        repeat (gap) @(negedge clk);
        step_en = 1'b1;
        @(negedge clk);
        step_en = 1'b0;
    endtask

    task automatic pulse_single();
        @(negedge clk);
        single = 1'b1;
        @(negedge clk);
        single = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        step_en = 1'b0;
        single  = 1'b0;
        start   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hold", 16'h0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic add(input logic [3:0] op, input logic [15:0] ec, input logic [2:0] es);
        vec_t v;
        v.op = op;
        v.ec = ec;
        v.es = es;
        tbl.push_back(v);
    endtask

    // Instruction-level model: the full list of words an opcode presents
    task automatic build_instr(input logic [3:0] op);
        words[0] = W_T1;
        words[1] = W_T2;
        nwords   = 2;
        case (op)
            4'b0001: begin words[2] = IR_OUT | MAR_IN; words[3] = RAM_OUT | A_IN; nwords = 4; end
            4'b0010: begin words[2] = IR_OUT | MAR_IN; words[3] = RAM_OUT | B_IN;
                           words[4] = ALU_OUT | A_IN | ALU_A; nwords = 5; end
            4'b0111: begin words[2] = IR_OUT | MAR_IN; words[3] = RAM_OUT | B_IN;
                           words[4] = ALU_OUT | A_IN | ALU_S; nwords = 5; end
            4'b0011: begin words[2] = A_OUT | OUT_IN; nwords = 3; end
            4'b0100: begin words[2] = IR_OUT | PC_IN; nwords = 3; end
            4'b0110: begin words[2] = IR_OUT | A_IMM; nwords = 3; end
            4'b0101: begin words[2] = IR_OUT | MAR_IN; words[3] = A_OUT | RAM_IN; nwords = 4; end
            default: nwords = 2;
        endcase
    endtask

    initial begin
        logic [W-1:0] e;
        logic [3:0]   cur_op;
        bit           m_idle;
        bit           m_active;
        int           pos;
        bit           r;

        // ---------------- table-driven sequence, run=1 ----------------
        add(4'b0110, W_T1, 3'd1);
        add(4'b0110, W_T2, 3'd2);
        add(4'b0110, IR_OUT | A_IMM, 3'd3);
        add(4'b0011, W_T1, 3'd1);
        add(4'b0011, W_T2, 3'd2);
        add(4'b0011, A_OUT | OUT_IN, 3'd3);
        add(4'b0010, W_T1, 3'd1);
        add(4'b0010, W_T2, 3'd2);
        add(4'b0010, IR_OUT | MAR_IN, 3'd3);
        add(4'b0010, RAM_OUT | B_IN, 3'd4);
        add(4'b0010, ALU_OUT | A_IN | ALU_A, 3'd5);
        add(4'b0111, W_T1, 3'd1);
        add(4'b0111, W_T2, 3'd2);
        add(4'b0111, IR_OUT | MAR_IN, 3'd3);
        add(4'b0111, RAM_OUT | B_IN, 3'd4);
        add(4'b0111, ALU_OUT | A_IN | ALU_S, 3'd5);
        add(4'b1010, W_T1, 3'd1);
        add(4'b1010, W_T2, 3'd2);
        add(4'b1010, W_T1, 3'd1);
        add(4'b0001, W_T2, 3'd2);
        add(4'b0001, IR_OUT | MAR_IN, 3'd3);
        add(4'b0001, RAM_OUT | A_IN, 3'd4);
        add(4'b0000, W_T1, 3'd1);
        add(4'b0000, W_T2, 3'd2);
        add(4'b0000, W_T1, 3'd1);

        run = 1'b1;
        do_reset();
        check("idle_after_reset", 16'h0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            opcode = tbl[i].op;
            do_step(i % 3);
            check($sformatf("tbl[%0d]", i), tbl[i].ec, tbl[i].es, 1'b0, 1'b0);
        end

        // ---------------- STA with run dropped in T4, then single ----------------
        opcode = 4'b0101;
        do_step(1); check("sta_t2", W_T2, 3'd2, 1'b0, 1'b0);
        do_step(0); check("sta_t3", IR_OUT | MAR_IN, 3'd3, 1'b0, 1'b0);
        do_step(2); check("sta_t4", A_OUT | RAM_IN, 3'd4, 1'b0, 1'b0);
        run = 1'b0;
        do_step(1); check("sta_pause", 16'h0, 3'd0, 1'b0, 1'b1);
        do_step(1); check("pause_hold", 16'h0, 3'd0, 1'b0, 1'b1);
        pulse_single();
        opcode = 4'b0001;
        do_step(2); check("single_t1", W_T1, 3'd1, 1'b0, 1'b0);
        pulse_single();  // not in PAUSE: must be dropped
        do_step(0); check("single_t2", W_T2, 3'd2, 1'b0, 1'b0);
        do_step(0); check("single_t3", IR_OUT | MAR_IN, 3'd3, 1'b0, 1'b0);
        do_step(0); check("single_t4", RAM_OUT | A_IN, 3'd4, 1'b0, 1'b0);
        do_step(0); check("single_repause", 16'h0, 3'd0, 1'b0, 1'b1);
        do_step(1); check("single_dropped", 16'h0, 3'd0, 1'b0, 1'b1);

        // ---------------- HLT, 20 quiet strobes, start ----------------
        run = 1'b1;
        opcode = 4'b1111;
        do_step(0); check("hlt_t1", W_T1, 3'd1, 1'b0, 1'b0);
        pulse_start();   // not in HALTED: must be dropped
        do_step(0); check("hlt_t2", W_T2, 3'd2, 1'b0, 1'b0);
        do_step(0); check("hlt_t3", 16'h0, 3'd3, 1'b0, 1'b0);
        do_step(0); check("hlt_enter", 16'h0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            do_step(i % 2);
            check($sformatf("hlt_hold[%0d]", i), 16'h0, 3'd0, 1'b1, 1'b0);
        end
        pulse_start();
        opcode = 4'b0100;
        do_step(1); check("start_t1", W_T1, 3'd1, 1'b0, 1'b0);
        do_step(0); check("jmp_t2", W_T2, 3'd2, 1'b0, 1'b0);
        do_step(0); check("jmp_t3", IR_OUT | PC_IN, 3'd3, 1'b0, 1'b0);

        // ---------------- async reset during JMP T3 ----------------
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 16'h0, 3'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_release", 16'h0, 3'd0, 1'b0, 1'b0);
        do_step(0); check("rst_t1", W_T1, 3'd1, 1'b0, 1'b0);

        // ---------------- randomized instruction stream ----------------
        do_reset();
        m_idle   = 1'b1;
        m_active = 1'b0;
        pos      = 0;
        cur_op   = 4'h0;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 3) != 0);
            if (m_idle || !m_active || pos == nwords - 1) begin
                if (m_idle || r) begin
                    cur_op = 4'($urandom_range(0, 14));
                    build_instr(cur_op);
                    pos      = 0;
                    m_active = 1'b1;
                    m_idle   = 1'b0;
                    exp_q.push_back({words[0], 3'd1, 1'b0, 1'b0});
                end else begin
                    m_active = 1'b0;
                    exp_q.push_back({16'h0, 3'd0, 1'b0, 1'b1});
                end
            end else begin
                pos++;
                exp_q.push_back({words[pos], 3'(pos + 1), 1'b0, 1'b0});
            end
            run    = r;
            opcode = cur_op;
            do_step($urandom_range(0, 2));
            e = exp_q.pop_front();
            check($sformatf("rand[%0d] op=%b", n, cur_op), e[20:5], e[4:2], e[1], e[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter MAX_STEP, default 5, giving the highest microstep index (T1..T5).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port step_en, input, 1 bit: one-clk strobe from the clock divider marking a CPU step edge.
REQ-005 SHALL have port opcode, input, 4 bits: the IR high nibble, valid from T3 onward.
REQ-006 SHALL have port run, input, 1 bit: level; 1 = free-run, 0 = pause at the next instruction boundary.
REQ-007 SHALL have port single, input, 1 bit: one-clk pulse that executes exactly one instruction while paused.
REQ-008 SHALL have port start, input, 1 bit: one-clk pulse that leaves HALTED.
REQ-009 SHALL have port ctrl, output, 16 bits: the control word {pc_in, pc_out, pc_add, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_imm_in, a_out, b_in, alu_out, output_in, alu_op[1:0]}.
REQ-010 SHALL have port step, output, 3 bits: the current microstep (1..MAX_STEP), or 0 when not executing.
REQ-011 SHALL have port halted, output, 1 bit: high while in the HALTED state.
REQ-012 SHALL have port paused, output, 1 bit: high while in the PAUSE state.

Function
REQ-013 SHALL implement the FSM states IDLE, FETCH, EXEC, PAUSE and HALTED; the FSM state, step and ctrl SHALL change only on clk edges where step_en=1, except for reset and the single/start capture latches.
REQ-014 SHALL register ctrl, with the word for step k presented from the step_en edge that ends step k-1 until the step_en edge that ends step k; the datapath latches on that ending edge.
REQ-015 SHALL make the transition IDLE->FETCH on the first step_en after reset, presenting T1.
REQ-016 SHALL assert pc_out and mar_in in FETCH step 1, and ram_out, ir_in and pc_add in FETCH step 2; EXEC begins with step 3.
REQ-017 SHALL drive the EXEC microcode for LDA (0001) as follows: T3 ir_out+mar_in; T4 ram_out+a_in; last step T4.
REQ-018 SHALL drive the EXEC microcode for ADD (0010) and SUB (0111) as follows: T3 ir_out+mar_in; T4 ram_out+b_in; T5 alu_out+a_in, with alu_op 01 for ADD and 10 for SUB; last step T5.
REQ-019 SHALL drive the EXEC microcode for OUT (0011) as a_out+output_in at T3, for JMP (0100) as ir_out+pc_in at T3, and for LDI (0110) as ir_out+a_imm_in at T3; the last step of each is T3.
REQ-020 SHALL drive the EXEC microcode for STA (0101) as follows: T3 ir_out+mar_in; T4 a_out+ram_in; last step T4.
REQ-021 SHALL treat NOP (0000) and undefined opcodes as having last step T2, with no EXEC control bits asserted.
REQ-022 SHALL, for HLT (1111), present ctrl=0 at T3 and then enter HALTED, with ctrl=0, step=0 and halted=1.
REQ-023 SHALL, after the last step of an instruction, go to FETCH T1 when run=1, or to PAUSE (paused=1, ctrl=0, step=0) when run=0.
REQ-024 SHALL, in PAUSE, go to FETCH T1 on a step_en when run=1 or when a single pulse has been captured; a captured single SHALL run one instruction and then return to PAUSE.
REQ-025 SHALL capture single and start pulses arriving between step_en strobes and hold them until consumed; pulses outside PAUSE or HALTED respectively SHALL be discarded.
REQ-026 SHALL make the transition HALTED->FETCH T1 on the first step_en after a captured start, with PC untouched.
REQ-027 SHALL never exceed MAX_STEP; any step beyond the last step SHALL force FETCH T1.
REQ-028 SHALL let run falling mid-instruction complete that instruction before pausing.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state=IDLE, ctrl=0, step=0, halted=0, paused=0 and clear the capture latches.
REQ-030 SHALL, when rst_n is asserted mid-instruction, abort the instruction with no partial control pulse after release.

Structure
REQ-031 SHALL place the opcode constants, the control-word bit positions, the alu_op encodings and the state enum in shared package cpu_pkg.
REQ-032 SHALL use combinational sub-module ucode_rom, mapping (opcode, step) to {ctrl, last_step}.

Verification
REQ-033 SHALL cover the scenario: reset, run=1, program LDI 1 / OUT -> ctrl sequence T1, T2, {ir_out, a_imm_in}, T1, T2, {a_out, output_in}.
REQ-034 SHALL cover the scenario: opcode=ADD -> T5 ctrl has alu_out+a_in with alu_op=01, followed by T1 on the next step_en; opcode=SUB gives alu_op=10.
REQ-035 SHALL cover the scenario: run dropped during T4 of STA -> T4 completes, then paused=1, ctrl=0; one single pulse executes exactly one instruction and paused=1 returns.
REQ-036 SHALL cover the scenario: opcode=HLT -> halted=1 and ctrl stays 0 over 20 step_en; a start pulse gives T1 on the next step_en.
REQ-037 SHALL cover the scenario: rst_n asserted asynchronously during T3 of JMP -> ctrl=0 within the same cycle, with no pc_in pulse after release.
REQ-038 SHALL cover the scenario: opcode=1010 (undefined) -> T1, T2, then T1, with no EXEC bits asserted.
